// File: rtl/adder_share_arb_if.sv
// Request/response bundle between NREQ client blocks and the shared adder
// arbiter. The master side is the client/consumer world, the slave side is
// the arbiter itself.
interface adder_share_arb_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ-1:0]   req_ci;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_s;
  logic              rsp_co;
  logic              rsp_os;

  modport master (
    output req_valid, req_a, req_b, req_ci, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_s, rsp_co, rsp_os
  );

  modport slave (
    input  req_valid, req_a, req_b, req_ci, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_s, rsp_co, rsp_os
  );
endinterface

// File: rtl/adder_share_arb.sv
// adder_share_arb: one carry-select adder_8 shared round-robin between NREQ
// requesters, with a single registered result slot tagged by requester id.
// Optional build macro ADDER_SHARE_STATS_EN adds per-requester saturating
// grant counters (stat_clr / grant_cnt ports).

// 8-bit carry-select adder: low nibble ripples, high nibble is precomputed
// for both carry-in values and selected by the low nibble carry.
module adder_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co,
  output logic       os
);
  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  assign lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, ci};
  assign hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
  assign hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;

  assign s[3:0] = lo[3:0];
  assign s[7:4] = lo[4] ? hi1[3:0] : hi0[3:0];
  assign co     = lo[4] ? hi1[4]   : hi0[4];
  // Signed overflow: like-signed operands producing a result of the other sign.
  assign os     = (a[7] == b[7]) & (s[7] != a[7]);
endmodule

module adder_share_arb #(
  parameter int NREQ = 4
`ifdef ADDER_SHARE_STATS_EN
  ,
  parameter int CNTW = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef ADDER_SHARE_STATS_EN
  input  logic                 stat_clr,
  output logic [NREQ*CNTW-1:0] grant_cnt,
`endif
  adder_share_arb_if.slave     bus
);
  localparam int IDW    = $clog2(NREQ);
  localparam int DATA_W = 8;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                  state;
  logic [IDW-1:0]          last_grant;
  logic                    grant_any;
  logic [IDW-1:0]          grant_idx;
  logic [NREQ-1:0]         grant_onehot;
  logic                    can_accept;
  logic                    xfer;

  logic signed [DATA_W-1:0] op_a_p0;
  logic signed [DATA_W-1:0] op_b_p0;
  logic                     op_ci_p0;
  logic [DATA_W-1:0]        sum_p0;
  logic                     co_p0;
  logic                     os_p0;

  logic [IDW-1:0]           id_p1;
  logic [DATA_W-1:0]        sum_p1;
  logic                     co_p1;
  logic                     os_p1;

  // Round-robin pick: scan from the requester after last_grant, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_any && bus.req_valid[(int'(last_grant) + k) % NREQ]) begin
        grant_any = 1'b1;
        grant_idx = IDW'((int'(last_grant) + k) % NREQ);
      end
    end
  end

  assign grant_onehot  = grant_any ? (NREQ'(1) << grant_idx) : '0;
  assign can_accept    = (state == EMPTY) | bus.rsp_ready;
  assign bus.req_ready = grant_onehot & {NREQ{can_accept}};
  assign xfer          = grant_any & can_accept;

  // Operand mux: the granted requester drives the shared adder.
  always_comb begin
    op_a_p0  = bus.req_a[8*int'(grant_idx) +: 8];
    op_b_p0  = bus.req_b[8*int'(grant_idx) +: 8];
    op_ci_p0 = bus.req_ci[grant_idx];
  end

  adder_8 u_adder (
    .a  (op_a_p0),
    .b  (op_b_p0),
    .ci (op_ci_p0),
    .s  (sum_p0),
    .co (co_p0),
    .os (os_p0)
  );

  // ---- p0 -> p1: result slot FSM, capture on transfer, advance pointer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      last_grant <= IDW'(NREQ - 1);
      id_p1      <= '0;
      sum_p1     <= '0;
      co_p1      <= 1'b0;
      os_p1      <= 1'b0;
    end else begin
      if (xfer) begin
        state      <= FULL;
        last_grant <= grant_idx;
        id_p1      <= grant_idx;
        sum_p1     <= sum_p0;
        co_p1      <= co_p0;
        os_p1      <= os_p0;
      end else if (state == FULL && bus.rsp_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_id    = id_p1;
  assign bus.rsp_s     = sum_p1;
  assign bus.rsp_co    = co_p1;
  assign bus.rsp_os    = os_p1;

`ifdef ADDER_SHARE_STATS_EN
  logic [NREQ-1:0][CNTW-1:0] cnt;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  // Per-requester transfer counters; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (stat_clr) begin
      cnt <= '0;
    end else if (xfer) begin
      cnt[grant_idx] <= sat_inc(cnt[grant_idx]);
    end
  end

  assign grant_cnt = cnt;
`endif
endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the arbiter and result slot.
module tb_adder_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = $clog2(NREQ);
`ifdef ADDER_SHARE_STATS_EN
  localparam int CNTW = 4;
  logic                 stat_clr;
  logic [NREQ*CNTW-1:0] grant_cnt;
  int                   m_cnt [NREQ];
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  adder_share_arb_if #(.NREQ(NREQ)) bus ();

  adder_share_arb #(
    .NREQ(NREQ)
`ifdef ADDER_SHARE_STATS_EN
    , .CNTW(CNTW)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef ADDER_SHARE_STATS_EN
    .stat_clr (stat_clr),
    .grant_cnt(grant_cnt),
`endif
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic            m_valid;
  int              m_id;
  int              m_s;
  int              m_co;
  int              m_os;
  int              m_last;
  logic [NREQ-1:0] m_ready;
  int              g;
  int              ua;
  int              sa;
  int              sum;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_last  = NREQ - 1;
      m_ready = '0;
      chk("rst_valid", 32'(bus.rsp_valid), 0);
      chk("rst_s", 32'(bus.rsp_s), 0);
      chk("rst_id", 32'(bus.rsp_id), 0);
`ifdef ADDER_SHARE_STATS_EN
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
`endif
    end else begin
      g = -1;
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && bus.req_valid[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
      m_ready = (g >= 0 && (!m_valid || bus.rsp_ready)) ? NREQ'(1) << g : '0;
      chk("req_ready", 32'(bus.req_ready), 32'(m_ready));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rsp_id", 32'(bus.rsp_id), m_id);
        chk("rsp_s", 32'(bus.rsp_s), m_s);
        chk("rsp_co", 32'(bus.rsp_co), m_co);
        chk("rsp_os", 32'(bus.rsp_os), m_os);
      end
`ifdef ADDER_SHARE_STATS_EN
      for (int i = 0; i < NREQ; i++)
        chk("grant_cnt", 32'(grant_cnt[i*CNTW +: CNTW]), m_cnt[i]);
      if (stat_clr) begin
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      end else if (m_ready != 0) begin
        if (m_cnt[g] < (1 << CNTW) - 1) m_cnt[g]++;
      end
`endif
      if (m_ready != 0) begin
        ua  = int'(bus.req_a[g*8 +: 8]) + int'(bus.req_b[g*8 +: 8]) + int'(bus.req_ci[g]);
        sa  = int'($signed(bus.req_a[g*8 +: 8])) + int'($signed(bus.req_b[g*8 +: 8]))
              + int'(bus.req_ci[g]);
        m_valid = 1'b1;
        m_id    = g;
        m_s     = ua % 256;
        m_co    = ua / 256;
        m_os    = (sa > 127 || sa < -128) ? 1 : 0;
        m_last  = g;
      end else if (m_valid && bus.rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic ci);
    bus.req_a[i*8 +: 8] = a;
    bus.req_b[i*8 +: 8] = b;
    bus.req_ci[i]       = ci;
  endtask

  // One operation from requester i, result checked the following cycle.
  task automatic op_check(input int i, input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic [7:0] es, input logic eco, input logic eos);
    @(posedge clk); #1;
    set_req(i, a, b, ci);
    bus.req_valid = NREQ'(1) << i;
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk("op_valid", 32'(bus.rsp_valid), 1);
    chk("op_id", 32'(bus.rsp_id), i);
    chk("op_s", 32'(bus.rsp_s), 32'(es));
    chk("op_co", 32'(bus.rsp_co), 32'(eco));
    chk("op_os", 32'(bus.rsp_os), 32'(eos));
  endtask

  logic [7:0] hold_s;
  logic [NREQ-1:0] hold;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_ci    = '0;
    bus.rsp_ready = 1'b1;
`ifdef ADDER_SHARE_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(bus.rsp_valid), 0);
    chk("reset_co", 32'(bus.rsp_co), 0);
    chk("reset_os", 32'(bus.rsp_os), 0);
    rst_n = 1'b1;

    // Single op: F6 + 0A = 1_00
    @(posedge clk); #1;
    set_req(0, 8'hF6, 8'h0A, 1'b0);
    bus.req_valid = 4'b0001;
    #1 chk("t1_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk("t1_valid", 32'(bus.rsp_valid), 1);
    chk("t1_id", 32'(bus.rsp_id), 0);
    chk("t1_s", 32'(bus.rsp_s), 32'h00);
    chk("t1_co", 32'(bus.rsp_co), 1);
    chk("t1_os", 32'(bus.rsp_os), 0);

    // Overflow/carry corners
    op_check(2, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op_check(2, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    op_check(1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    op_check(3, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

    // Round-robin with all four requesting (pointer now at 3)
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h11 * i), 8'h03, i[0]);
    @(posedge clk); #1;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("rr_valid", 32'(bus.rsp_valid), 1);
      chk("rr_id", 32'(bus.rsp_id), k % NREQ);
    end

    // Backpressure: hold FULL for 5 cycles
    bus.rsp_ready = 1'b0;
    hold_s = bus.rsp_s;
    chk("bp_s_lit", 32'(hold_s), 32'h15);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(bus.rsp_valid), 1);
      chk("bp_id", 32'(bus.rsp_id), 1);
      chk("bp_s", 32'(bus.rsp_s), 32'(hold_s));
      chk("bp_ready", 32'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(bus.req_ready), 32'b0100);
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    chk("bp_next_id", 32'(bus.rsp_id), 2);
    chk("bp_next_s", 32'(bus.rsp_s), 32'h25);

    // Asynchronous reset while FULL
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", 32'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1010;
    #1 chk("post_rst_ready", 32'(bus.req_ready), 32'b0010);
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk("post_rst_id", 32'(bus.rsp_id), 1);

`ifdef ADDER_SHARE_STATS_EN
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    bus.req_valid = 4'b0100;
    repeat (3) @(posedge clk);
    #1;
    bus.req_valid = '0;
    chk("stat_cnt2", 32'(grant_cnt[2*CNTW +: CNTW]), 3);
    chk("stat_cnt0", 32'(grant_cnt[0 +: CNTW]), 0);
    bus.req_valid = 4'b0001;
    repeat (20) @(posedge clk);
    #1;
    bus.req_valid = '0;
    chk("stat_sat", 32'(grant_cnt[0 +: CNTW]), 32'hF);
    stat_clr = 1'b1;
    bus.req_valid = 4'b0001;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    bus.req_valid = '0;
    chk("stat_clr", 32'(grant_cnt), 0);
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      hold = bus.req_valid & ~m_ready;
      rst_n = ($urandom % 500) != 0;
      bus.rsp_ready = ($urandom % 4) != 0;
`ifdef ADDER_SHARE_STATS_EN
      stat_clr = ($urandom % 64) == 0;
`endif
      for (int i = 0; i < NREQ; i++) begin
        if (hold[i]) begin
          bus.req_valid[i] = ($urandom % 8) != 0;
        end else begin
          bus.req_valid[i] = $urandom % 2;
          set_req(i, 8'($urandom), 8'($urandom), 1'($urandom));
        end
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
